// File: rtl/spi_mem_responder_pkg.sv
// Constants and state encoding shared by the SPI memory responder and the
// CPU-side SPI memory controller.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_mem_responder_input_sync.sv
// Two-flop synchronisers for the SPI pins plus sclk edge detection on the
// synchronised copy.
module spi_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic r_sclk_meta, r_sclk_s, r_sclk_d;
  logic r_cs_meta, r_cs_s;
  logic r_mosi_meta, r_mosi_s;

  // cs resets to its idle (deselected) level so busy starts low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_s    <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_s      <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_s    <= 1'b0;
    end else begin
      r_sclk_meta <= sclk;
      r_sclk_s    <= r_sclk_meta;
      r_sclk_d    <= r_sclk_s;
      r_cs_meta   <= cs;
      r_cs_s      <= r_cs_meta;
      r_mosi_meta <= mosi;
      r_mosi_s    <= r_mosi_meta;
    end
  end

  assign sclk_rise = r_sclk_s & ~r_sclk_d;
  assign sclk_fall = ~r_sclk_s & r_sclk_d;
  assign cs_n_s    = r_cs_s;
  assign mosi_s    = r_mosi_s;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial SRAM model: READ/WRITE commands with a 24-bit address over
// an internal byte array, plus a backdoor load port.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         cs,
  input  logic                         mosi,
  output logic                         miso,
  input  logic                         load_en,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                   load_data,
  output logic                         busy,
  output logic                         cmd_err,
  output state_t                       o_dbg_state
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  logic w_sclk_rise, w_sclk_fall, w_cs_n_s, w_mosi_s;

  spi_input_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .sclk_rise (w_sclk_rise),
    .sclk_fall (w_sclk_fall),
    .cs_n_s    (w_cs_n_s),
    .mosi_s    (w_mosi_s)
  );

  logic [7:0]       r_mem [MEM_BYTES];
  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt;
  logic [6:0]       r_shift, w_shift_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_is_wr, w_is_wr_nxt;
  logic             r_miso, w_miso_nxt;
  logic             r_cmd_err, w_cmd_err_nxt;
  logic             w_wr_en;
  logic [7:0]       w_byte, w_rd_byte;
  logic [1:0]       r_settle;
  logic             r_cs_seen_high;
  logic             r_ld_en;
  logic [IDX_W-1:0] r_ld_addr;
  logic [7:0]       r_ld_data;

  assign w_byte    = {r_shift, w_mosi_s};
  assign w_rd_byte = r_mem[r_idx];

  // A transaction may only start once cs has been seen high after reset, so a
  // reset in mid-transaction is never resumed from the middle of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle       <= 2'b00;
      r_cs_seen_high <= 1'b0;
    end else begin
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && w_cs_n_s) r_cs_seen_high <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_idx_nxt     = r_idx;
    w_is_wr_nxt   = r_is_wr;
    w_miso_nxt    = r_miso;
    w_cmd_err_nxt = 1'b0;
    w_wr_en       = 1'b0;
    if (w_cs_n_s) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 5'd0;
      w_miso_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cs_seen_high) begin
            w_state_nxt = ST_CMD;
            w_cnt_nxt   = 5'd0;
          end
        end
        ST_CMD: begin
          if (w_sclk_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              w_cnt_nxt = 5'd0;
              if (w_byte == CMD_READ || w_byte == CMD_WRITE) begin
                w_state_nxt = ST_ADDR;
                w_is_wr_nxt = (w_byte == CMD_WRITE);
              end else begin
                w_state_nxt   = ST_IGNORE;
                w_cmd_err_nxt = 1'b1;
              end
            end
          end
        end
        ST_ADDR: begin
          // Only the low IDX_W address bits survive the shift, so addresses alias.
          if (w_sclk_rise) begin
            w_idx_nxt = {r_idx[IDX_W-2:0], w_mosi_s};
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == 5'(ADDR_BITS - 1)) begin
              w_cnt_nxt   = 5'd0;
              w_state_nxt = r_is_wr ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (w_sclk_fall) begin
            w_miso_nxt = w_rd_byte[3'd7 - r_cnt[2:0]];
            w_cnt_nxt  = r_cnt + 5'd1;
            if (r_cnt[2:0] == 3'd7) begin
              w_cnt_nxt = 5'd0;
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (w_sclk_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              w_wr_en   = 1'b1;
              w_cnt_nxt = 5'd0;
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        ST_IGNORE: w_miso_nxt = 1'b0;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 5'd0;
      r_shift   <= 7'd0;
      r_idx     <= '0;
      r_is_wr   <= 1'b0;
      r_miso    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_ld_en   <= 1'b0;
      r_ld_addr <= '0;
      r_ld_data <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_is_wr   <= w_is_wr_nxt;
      r_miso    <= w_miso_nxt;
      r_cmd_err <= w_cmd_err_nxt;
      r_ld_en   <= load_en;
      r_ld_addr <= load_addr;
      r_ld_data <= load_data;
    end
  end

  // Backdoor load is applied last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_idx] <= w_byte;
    if (r_ld_en) r_mem[r_ld_addr] <= r_ld_data;
  end

  assign miso        = r_miso;
  assign busy        = ~w_cs_n_s;
  assign cmd_err     = r_cmd_err;
  assign o_dbg_state = r_state;

endmodule
